// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of a registered 32-bit ALU: one instruction in flight.
// Optional macro ALU_ILLEGAL_OP_TRAP_EN traps ops 3'b110/3'b111 instead of issuing them.
module alu_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int RA_W    = 3,
    parameter int ALU_LAT = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [3+3*RA_W-1:0] instr,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [2:0]          alu_sel,
    input  logic [DATA_W-1:0]   alu_r,
    input  logic                alu_z,
    output logic                wb_valid,
    output logic [RA_W-1:0]     wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic                z_flag,
    input  logic                ld_en,
    input  logic [RA_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic [RA_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]   dbg_data,
    output logic                err_illegal
);

    localparam int NREG  = 2**RA_W;
    localparam int CNT_W = $clog2(ALU_LAT);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [RA_W-1:0]       rd_q;
    logic [DATA_W-1:0]     regs [NREG];
    logic                  err_q;
    logic                  illegal;

    logic [2:0]            op;
    logic [RA_W-1:0]       rd;
    logic [RA_W-1:0]       ra;
    logic [RA_W-1:0]       rb;

    assign op = instr[3+3*RA_W-1 -: 3];
    assign rd = instr[3*RA_W-1 -: RA_W];
    assign ra = instr[2*RA_W-1 -: RA_W];
    assign rb = instr[RA_W-1:0];

`ifdef ALU_ILLEGAL_OP_TRAP_EN
    assign illegal = (op[2:1] == 2'b11);
`else
    assign illegal = 1'b0;
`endif

    assign instr_ready = (state == IDLE) && RST_N;
    assign err_illegal = err_q;
    // Entry 0 is never written, so it reads as zero without a mux.
    assign dbg_data    = regs[dbg_addr];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_q     <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            z_flag   <= 1'b0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wb_valid <= 1'b0;
            // Host load first so a same-edge writeback below takes priority.
            if (ld_en && ld_addr != '0) begin
                regs[ld_addr] <= ld_data;
            end
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            alu_a   <= regs[ra];
                            alu_b   <= regs[rb];
                            alu_sel <= op;
                            rd_q    <= rd;
                            cnt     <= CNT_W'(ALU_LAT - 1);
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        state <= WB;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WB: begin
                    if (rd_q != '0) begin
                        regs[rd_q] <= alu_r;
                    end
                    z_flag   <= alu_z;
                    wb_valid <= 1'b1;
                    wb_addr  <= rd_q;
                    wb_data  <= alu_r;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: a registered ALU stand-in plus a transaction-level model.
module tb_alu_issue_ctrl;

    localparam int ALU_LAT = 2;

    logic        CLK;
    logic        RST_N;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_r;
    logic        alu_z;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        z_flag;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        err_illegal;

    alu_issue_ctrl #(.DATA_W(32), .RA_W(3), .ALU_LAT(ALU_LAT)) dut (
        .CLK(CLK), .RST_N(RST_N), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_r(alu_r), .alu_z(alu_z), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .z_flag(z_flag), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .err_illegal(err_illegal)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a & b;
            3'b010:  return a | b;
            3'b011:  return a * b;
            3'b100:  return a - b;
            3'b101:  return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // ALU stand-in: result one edge after operands, zero flag one edge after result.
    always @(posedge CLK) begin
        alu_r <= alu_f(alu_sel, alu_a, alu_b);
        alu_z <= (alu_r == 32'd0);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural registers plus one pending instruction.
    logic [31:0] m_regs [8];
    int          m_busy;
    logic [2:0]  m_rd;
    logic [31:0] m_res;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_sel;
    logic        m_wb_v;
    logic [2:0]  m_wb_addr;
    logic [31:0] m_wb_data;
    logic        m_z;
    logic        m_err;

    task automatic model_edge(input logic rst, input logic v, input logic [11:0] ins,
                              input logic ld, input logic [2:0] la, input logic [31:0] ldd);
        logic [31:0] old [8];
        logic [2:0]  op, rd, ra, rb;
        logic        illegal;
        old = m_regs;
        {op, rd, ra, rb} = ins;
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            m_busy = 0; m_a = '0; m_b = '0; m_sel = '0;
            m_wb_v = 1'b0; m_z = 1'b0; m_err = 1'b0;
        end else begin
            m_wb_v = 1'b0;
            if (ld && la != 3'd0) m_regs[la] = ldd;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    if (m_rd != 3'd0) m_regs[m_rd] = m_res;
                    m_wb_v    = 1'b1;
                    m_wb_addr = m_rd;
                    m_wb_data = m_res;
                    m_z       = (m_res == 32'd0);
                end
            end else if (v) begin
                illegal = 1'b0;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
                illegal = (op[2:1] == 2'b11);
`endif
                if (illegal) begin
                    m_err = 1'b1;
                end else begin
                    m_a    = old[ra];
                    m_b    = old[rb];
                    m_sel  = op;
                    m_rd   = rd;
                    m_res  = alu_f(op, old[ra], old[rb]);
                    m_busy = ALU_LAT + 1;
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [11:0] ins,
                        input logic ld, input logic [2:0] la, input logic [31:0] ldd,
                        input logic [2:0] da);
        @(negedge CLK);
        RST_N = rst; instr_valid = v; instr = ins;
        ld_en = ld; ld_addr = la; ld_data = ldd; dbg_addr = da;
        @(posedge CLK);
        model_edge(rst, v, ins, ld, la, ldd);
        #1;
        check("instr_ready", {31'd0, instr_ready}, {31'd0, (m_busy == 0) && rst});
        check("wb_valid", {31'd0, wb_valid}, {31'd0, m_wb_v});
        if (m_wb_v) begin
            check("wb_addr", {29'd0, wb_addr}, {29'd0, m_wb_addr});
            check("wb_data", wb_data, m_wb_data);
        end
        check("z_flag", {31'd0, z_flag}, {31'd0, m_z});
        check("err_illegal", {31'd0, err_illegal}, {31'd0, m_err});
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_sel", {29'd0, alu_sel}, {29'd0, m_sel});
        check("dbg_data", dbg_data, m_regs[da]);
    endtask

    task automatic idle(input int n, input logic [2:0] da);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 12'd0, 1'b0, 3'd0, 32'd0, da);
    endtask

    task automatic load(input logic [2:0] la, input logic [31:0] ldd);
        step(1'b1, 1'b0, 12'd0, 1'b1, la, ldd, la);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb);
        step(1'b1, 1'b1, {op, rd, ra, rb}, 1'b0, 3'd0, 32'd0, rd);
    endtask

    initial begin
        step(1'b0, 1'b0, 12'd0, 1'b0, 3'd0, 32'd0, 3'd0);
        step(1'b0, 1'b0, 12'd0, 1'b0, 3'd0, 32'd0, 3'd0);
        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        issue(3'b000, 3'd3, 3'd1, 3'd2);           // ADD r3 = 8
        idle(4, 3'd3);
        check("r3_after_add", dbg_data, 32'd8);
        issue(3'b100, 3'd4, 3'd1, 3'd1); idle(3, 3'd4);  // SUB -> 0
        issue(3'b101, 3'd5, 3'd2, 3'd1); idle(3, 3'd5);  // 3<5 -> 1
        issue(3'b101, 3'd5, 3'd1, 3'd2); idle(3, 3'd5);  // 5<3 -> 0
        load(3'd1, 32'h0001_0000);
        issue(3'b011, 3'd6, 3'd1, 3'd1); idle(3, 3'd6);  // MUL wraps to 0
        load(3'd1, 32'hF0F0_F0F0);
        load(3'd2, 32'h0FF0_0FF0);
        issue(3'b001, 3'd6, 3'd1, 3'd2); idle(3, 3'd6);
        issue(3'b010, 3'd7, 3'd1, 3'd2); idle(3, 3'd7);
        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        // Valid held high: second instruction waits for the first to retire.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, {3'b000, 3'd3, 3'd1, 3'd2}, 1'b0, 3'd0, 32'd0, 3'd3);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, {3'b000, 3'd7, 3'd3, 3'd3}, 1'b0, 3'd0, 32'd0, 3'd7);
        idle(1, 3'd7);
        check("r7_dependent", dbg_data, 32'd16);
        issue(3'b000, 3'd0, 3'd1, 3'd2); idle(3, 3'd0);  // rd=0 still pulses
        // Host load to r3 on the writeback edge loses to the writeback.
        issue(3'b000, 3'd3, 3'd1, 3'd2);
        idle(2, 3'd3);
        step(1'b1, 1'b0, 12'd0, 1'b1, 3'd3, 32'd99, 3'd3);
        idle(1, 3'd3);
        check("r3_wb_wins", dbg_data, 32'd8);
        // Reset during EXEC drops the instruction.
        issue(3'b000, 3'd4, 3'd1, 3'd2);
        step(1'b0, 1'b0, 12'd0, 1'b0, 3'd0, 32'd0, 3'd1);
        idle(4, 3'd1);
        load(3'd1, 32'd7);
        issue(3'b110, 3'd5, 3'd1, 3'd1); idle(4, 3'd5);

        for (int i = 0; i < 3000; i++) begin
            logic        rst;
            logic [31:0] ldd;
            rst = ($urandom_range(0, 149) != 0);
            ldd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
            step(rst, ($urandom_range(0, 9) < 6), 12'($urandom_range(0, 4095)),
                 ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), ldd,
                 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
